// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits at CLK_DIV clocks per bit.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (even, or odd when PARITY_ODD=1).
`timescale 1ns/1ps

module uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_tx: parameter out of legal range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_tx;
    logic                   r_busy;

    state_t                 w_state_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [IDX_W-1:0]       w_idx_next;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic                   w_tx_next;
    logic                   w_busy_next;
    logic                   w_bit_end;

`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
    logic                   w_parity_next;
`endif

    assign w_bit_end = (r_cnt == CNT_LAST);

    // Next-state and next-output logic; tx is computed one edge early so it leaves a flop.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_state_next = r_state;
        w_cnt_next   = (r_state == S_IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_busy_next  = r_busy;
`ifdef UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif

        case (r_state)
            S_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (en) begin
                    w_state_next = S_START;
                    w_shift_next = data;
                    w_idx_next   = '0;
                    w_tx_next    = 1'b0;
                    w_busy_next  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = 1'(PARITY_ODD);
`endif
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_idx_next   = '0;
                    w_tx_next    = r_shift[0];
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = r_parity ^ r_shift[0];
`endif
                    if (r_idx == DATA_LAST) begin
                        w_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
                        w_tx_next    = r_parity ^ r_shift[0];
`else
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                        w_tx_next  = r_shift[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_idx_next   = '0;
                    w_tx_next    = 1'b1;
                end
            end
`endif

            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    if (r_idx == STOP_LAST) begin
                        w_state_next = S_IDLE;
                        w_idx_next   = '0;
                        w_busy_next  = 1'b0;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // Reset aborts any frame in flight and forces the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            // NOTE: state flops use non-blocking assignments so every register sees pre-edge values.
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter; the transmit-side counterpart to the existing uart_rx on the same serial line format.
- Accepts a parallel word through a single-cycle en/busy handshake.
- Serializes it LSB-first as start bit, data bits, optional parity bit and stop bit(s), at a fixed baud set by a clock divider.
- Sits between core logic and the tx pin; pairs with uart_rx for loopback tests.

Parameters:
CLK_DIV, 868, clk cycles per bit (100 MHz / 115200); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..8
STOP_BITS, 1, number of stop bits; legal values 1 or 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset; 0 resets the block immediately
en  input  1  transmit request; sampled on a rising edge while busy==0
data  input  DATA_BITS  word to send; captured on the accepting edge
tx  output  1  serial line; idle high
busy  output  1  high from the accepting edge until the frame ends

Behaviour:
- Reset (rst==0, asynchronous):
  - tx=1, busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
  - A frame in progress is aborted and tx returns high immediately, with no partial stop bit.
  - Release of rst is synchronous in effect: first acceptance is possible on the first clk edge after rst rises.
- Outputs tx and busy are registered; there is no combinational path from inputs to outputs.
- Handshake:
  - en is accepted on an edge where en==1 and busy==0. On that edge: data is latched, busy<=1, tx<=0 (start bit), state<=START.
  - en while busy==1 is ignored. No queueing, no error flag.
  - data may change freely after the accepting edge.
- States:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right each bit; bit index counts 0..DATA_BITS-1.
  - PARITY: present only with the macro.
  - STOP: tx=1 for STOP_BITS bit times.
- Bit timing:
  - Baud counter runs 0..CLK_DIV-1 in every non-IDLE state. Each bit, including each stop bit, holds for exactly CLK_DIV clk cycles.
  - Transitions occur on the edge where counter==CLK_DIV-1; counter wraps to 0.
- Frame length:
  - F = 1 + DATA_BITS + P + STOP_BITS bits, where P=1 with parity and 0 without.
  - tx is low on the accepting edge; busy falls F*CLK_DIV cycles later, on the edge ending the last stop bit. State returns to IDLE on that same edge.
- Back-to-back frames:
  - en held high continuously is accepted on the first edge after busy falls.
  - Minimum line idle between frames is therefore 1 clk cycle beyond the stop bit(s).
- Arithmetic widths:
  - Counter is $clog2(CLK_DIV) bits.
  - Bit index is $clog2(DATA_BITS+1) bits.
  - No overflow is possible within the legal parameter ranges.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA. tx = XOR of the latched data bits, XOR PARITY_ODD, held for CLK_DIV cycles.
  - Parity is computed from the latched copy, not the live data input.
  - F includes the parity bit.
- Undefined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.
  - PARITY_ODD is ignored.

Test Plan:
1. Reset with CLK_DIV=4, no parity: rst=0 then 1 -> tx=1, busy=0. Pulse en with data=0xA5 -> tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; busy high for exactly 40 cycles.
2. en held high, data=0x3C then 0xC3 (data switches after first acceptance) -> two complete frames. Second start bit begins 1 cycle after busy falls. Decoded bytes are 0x3C, 0xC3.
3. Pulse en again mid-frame with data=0xFF -> ignored. Frame still carries the original 0x00; busy timing unchanged.
4. Pull rst low during bit 3 of a frame -> tx=1 and busy=0 asynchronously, before the next clk edge. A fresh frame sent after release with data=0x81 is correct.
5. UART_TX_PARITY_EN defined, PARITY_ODD=0, CLK_DIV=4: data=0xA5 -> parity bit 0, frame 44 cycles. data=0x01 -> parity bit 1. With PARITY_ODD=1, data=0xA5 -> parity bit 1.
6. Loopback, STOP_BITS=2, CLK_DIV=868: tx drives uart_rx.rx for bytes 0x00, 0x55, 0xFF -> uart_rx reports the same bytes. busy high for 11*868 cycles per frame.
